// File: rtl/pea_evp_horner.sv
// pea_evp_horner: polynomial evaluation engine (Horner's rule).
//
// After an accepted start, reads N+1 signed coefficients starting at c_N
// (address coef_base+N) down to c0 (address coef_base), accumulating
// acc = acc*x + c_i. It then issues one write strobe to the result/status
// FIFOs and a one-cycle firing-complete pulse.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   start, N, x,    command; N/x/coef_base are latched when start is
//   coef_base       accepted in IDLE
//   coef_rd_en,     memory read strobe and address (registered, valid in
//   coef_addr       the read cycle itself)
//   coef_data       coefficient, valid one cycle after coef_rd_en
//   out_full        output FIFO back-pressure
//   wr_out          one-cycle write strobe to both output FIFOs
//   result, status  p(x) and {.., invalid_n, overflow}
//   busy, FC        state != IDLE, firing-complete pulse
//
// Build option: define PEA_EVP_SATURATE_EN to clamp the accumulator on
// overflow; otherwise the accumulator wraps to the low 32 bits.
module pea_evp_horner #(
    parameter int width       = 16,
    parameter int buffer_size = 1024,
    parameter int MAX_N       = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [4:0]                     N,
    input  logic [width-1:0]               x,
    input  logic [$clog2(buffer_size)-1:0] coef_base,
    output logic                           coef_rd_en,
    output logic [$clog2(buffer_size)-1:0] coef_addr,
    input  logic [width-1:0]               coef_data,
    input  logic                           out_full,
    output logic                           wr_out,
    output logic [31:0]                    result,
    output logic [31:0]                    status,
    output logic                           busy,
    output logic                           FC
);

    localparam int AW = $clog2(buffer_size);
    localparam int PW = 32 + width;   // full product width
    localparam int SW = PW + 1;       // sum width

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_TOP = 3'd1,
        LD_TOP = 3'd2,
        RD     = 3'd3,
        MAC    = 3'd4,
        WRITE  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t                   state_q, state_d;
    logic [4:0]               n_q, n_d;
    logic [4:0]               i_q, i_d;
    logic signed [width-1:0]  x_q, x_d;
    logic [AW-1:0]            base_q, base_d;
    logic signed [31:0]       acc_q, acc_d;
    logic [31:0]              result_q, result_d;
    logic                     ovf_q, ovf_d;
    logic                     inv_q, inv_d;
    logic                     rd_en_q, rd_en_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic                     wr_q, wr_d;
    logic                     fc_q, fc_d;
    logic                     busy_q, busy_d;

    logic signed [PW-1:0]     prod_s;
    logic signed [SW-1:0]     sum_s;
    logic                     ovf_s;
    logic [31:0]              mac_val_s;
    logic                     n_bad_s;

    // Multiply-accumulate datapath with overflow detection and policy.
    always_comb begin
        prod_s  = PW'(acc_q) * PW'(x_q);
        sum_s   = SW'(prod_s) + SW'($signed(coef_data));
        // Sum fits in 32 bits only if all bits above bit 31 equal bit 31.
        ovf_s   = (sum_s[SW-1:31] != {(SW-31){sum_s[31]}});
        n_bad_s = ({27'd0, N} > 32'(MAX_N));
        if (ovf_s) begin
`ifdef PEA_EVP_SATURATE_EN
            mac_val_s = sum_s[SW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
            mac_val_s = sum_s[31:0];
`endif
        end else begin
            mac_val_s = sum_s[31:0];
        end
    end

    // Next-state and next-output logic for the evaluation sequencer.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        i_d      = i_q;
        x_d      = x_q;
        base_d   = base_q;
        acc_d    = acc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        inv_d    = inv_q;
        rd_en_d  = 1'b0;
        addr_d   = addr_q;
        wr_d     = 1'b0;
        fc_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ovf_d    = 1'b0;
                    result_d = 32'd0;
                    if (n_bad_s) begin
                        inv_d   = 1'b1;
                        state_d = WRITE;
                    end else begin
                        inv_d   = 1'b0;
                        n_d     = N;
                        x_d     = x;
                        base_d  = coef_base;
                        // Registered strobe: asserted during the RD_TOP cycle.
                        rd_en_d = 1'b1;
                        addr_d  = coef_base + AW'(N);
                        state_d = RD_TOP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_TOP: state_d = LD_TOP;
            LD_TOP: begin
                acc_d = 32'($signed(coef_data));
                if (n_q == 5'd0) begin
                    result_d = acc_d;
                    state_d  = WRITE;
                end else begin
                    i_d     = n_q - 5'd1;
                    rd_en_d = 1'b1;
                    addr_d  = base_q + AW'(i_d);
                    state_d = RD;
                end
            end
            RD: state_d = MAC;
            MAC: begin
                acc_d = mac_val_s;
                ovf_d = ovf_q | ovf_s;
                if (i_q == 5'd0) begin
                    result_d = mac_val_s;
                    state_d  = WRITE;
                end else begin
                    i_d     = i_q - 5'd1;
                    rd_en_d = 1'b1;
                    addr_d  = base_q + AW'(i_d);
                    state_d = RD;
                end
            end
            WRITE: begin
                if (!out_full) begin
                    wr_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = WRITE;
                end
            end
            DONE: begin
                fc_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            n_q      <= 5'd0;
            i_q      <= 5'd0;
            x_q      <= '0;
            base_q   <= '0;
            acc_q    <= 32'sd0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            fc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            i_q      <= i_d;
            x_q      <= x_d;
            base_q   <= base_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
            rd_en_q  <= rd_en_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            fc_q     <= fc_d;
            busy_q   <= busy_d;
        end
    end

    assign coef_rd_en = rd_en_q;
    assign coef_addr  = addr_q;
    assign wr_out     = wr_q;
    assign result     = result_q;
    assign status     = {30'd0, inv_q, ovf_q};
    assign busy       = busy_q;
    assign FC         = fc_q;

endmodule

// File: tb/tb_pea_evp_horner.sv
// Testbench for pea_evp_horner: directed runs checked against a Horner
// reference model evaluated over the bench's own coefficient memory.
module tb_pea_evp_horner;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  N;
    logic [15:0] x;
    logic [9:0]  coef_base;
    logic        coef_rd_en;
    logic [9:0]  coef_addr;
    logic [15:0] coef_data;
    logic        out_full;
    logic        wr_out;
    logic [31:0] result;
    logic [31:0] status;
    logic        busy;
    logic        FC;

    int tests = 0;
    int fails = 0;

    logic signed [15:0] mem [1024];
    logic [31:0] exp_result;
    logic [31:0] exp_status;

    pea_evp_horner #(.width(16), .buffer_size(1024), .MAX_N(10)) dut (
        .clk(clk), .rst(rst), .start(start), .N(N), .x(x),
        .coef_base(coef_base), .coef_rd_en(coef_rd_en), .coef_addr(coef_addr),
        .coef_data(coef_data), .out_full(out_full), .wr_out(wr_out),
        .result(result), .status(status), .busy(busy), .FC(FC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: registered read, data valid one cycle after the strobe.
    always @(posedge clk) begin
        if (coef_rd_en) coef_data <= mem[coef_addr];
    end

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: p(x) by Horner with plain 64-bit integer arithmetic.
    task automatic model(input int n, input logic signed [15:0] xv, input logic [9:0] base,
                         output logic [31:0] r, output logic [31:0] s);
        longint acc;
        longint sum;
        bit     ovf;
        if (n > 10) begin
            r = 32'd0;
            s = 32'd2;
            return;
        end
        acc = longint'(mem[(int'(base) + n) % 1024]);
        ovf = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            sum = acc * longint'(xv) + longint'(mem[(int'(base) + i) % 1024]);
            if (sum > 64'sh7FFF_FFFF || sum < -64'sh8000_0000) begin
                ovf = 1'b1;
`ifdef PEA_EVP_SATURATE_EN
                acc = (sum > 0) ? 64'sh7FFF_FFFF : -64'sh8000_0000;
`else
                acc = longint'($signed(sum[31:0]));
`endif
            end else begin
                acc = sum;
            end
        end
        r = acc[31:0];
        s = {31'd0, ovf};
    endtask

    // Compare process: every write strobe must carry the model's words,
    // and the write and completion pulses must never coincide.
    always @(negedge clk) begin
        if (wr_out) begin
            chk("result_at_wr", longint'(result), longint'(exp_result));
            chk("status_at_wr", longint'(status), longint'(exp_status));
        end
        if (wr_out || FC) begin
            chk("wr_fc_exclusive", longint'(wr_out && FC), 64'd0);
        end
    end

    // One evaluation: checks latency, pulse counts, read count, result hold.
    task automatic run(input string tag, input int n, input logic [15:0] xv,
                       input logic [9:0] base, input int stall, input int busy_e);
        int w0, e, wr_e, fc_e, wr_cnt, rd_cnt;
        model(n, xv, base, exp_result, exp_status);
        w0 = (n > 10) ? 1 : 2 * n + 3;
        @(negedge clk);
        start = 1'b1; N = n[4:0]; x = xv; coef_base = base; out_full = (stall > 0);
        @(posedge clk); #1;
        start = 1'b0;
        e = 0; wr_e = -1; fc_e = -1; wr_cnt = 0; rd_cnt = 0;
        while (e < 200 && fc_e < 0) begin
            if (coef_rd_en) rd_cnt++;
            if (wr_out) begin wr_cnt++; wr_e = e; end
            if (FC) fc_e = e;
            if (e >= w0 - 1 && e <= w0 + stall)
                chk({tag, "_result_hold"}, longint'(result), longint'(exp_result));
            if (e == w0 - 1 + stall) out_full = 1'b0;
            if (e == busy_e) begin start = 1'b1; N = 5'd0; x = 16'd3; end
            else start = 1'b0;
            @(posedge clk); #1;
            e++;
        end
        start = 1'b0;
        chk({tag, "_wr_edge"}, longint'(wr_e), longint'(w0 + stall));
        chk({tag, "_fc_edge"}, longint'(fc_e), longint'(w0 + stall + 1));
        chk({tag, "_wr_count"}, longint'(wr_cnt), 64'd1);
        chk({tag, "_rd_count"}, longint'(rd_cnt), (n > 10) ? 64'd0 : longint'(n + 1));
    endtask

    logic [31:0] pr, ps;

    initial begin
        rst = 1'b0; start = 1'b0; N = 5'd0; x = 16'd0; coef_base = 10'd0;
        out_full = 1'b0; coef_data = 16'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'sd0;
        exp_result = 32'd0; exp_status = 32'd0;

        // Coefficient tables.
        mem[10] = 16'sd5;
        mem[20] = 16'sd1; mem[21] = 16'sd2; mem[22] = 16'sd3; mem[23] = 16'sd4;
        mem[42] = 16'sh7FFF;
        mem[52] = -16'sd32768;
        mem[1022] = 16'sd7; mem[1023] = -16'sd1; mem[0] = 16'sd0; mem[1] = 16'sd2;
        mem[100] = 16'sd1; mem[101] = -16'sd2; mem[102] = 16'sd3;
        mem[103] = -16'sd4; mem[104] = 16'sd5; mem[105] = -16'sd6;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en",  longint'(coef_rd_en), 64'd0);
        chk("rst_addr",   longint'(coef_addr), 64'd0);
        chk("rst_wr_out", longint'(wr_out), 64'd0);
        chk("rst_result", longint'(result), 64'd0);
        chk("rst_status", longint'(status), 64'd0);
        chk("rst_busy",   longint'(busy), 64'd0);
        chk("rst_fc",     longint'(FC), 64'd0);
        @(negedge clk); rst = 1'b1;

        // Hand-computed values pinning the reference model.
        model(0, 16'sd9, 10'd10, pr, ps);  chk("pin_n0", longint'(pr), 64'd5);
        model(3, 16'sd2, 10'd20, pr, ps);  chk("pin_n3_x2", longint'(pr), 64'd49);
        model(3, -16'sd1, 10'd20, pr, ps); chk("pin_n3_xm1", longint'(pr), 64'hFFFF_FFFE);
        model(5, 16'sd3, 10'd100, pr, ps); chk("pin_n5", longint'(pr), 64'hFFFF_FB8D);
        model(2, 16'sh7FFF, 10'd40, pr, ps);
        chk("pin_ovf_status", longint'(ps), 64'd1);
`ifdef PEA_EVP_SATURATE_EN
        chk("pin_ovf_pos", longint'(pr), 64'h7FFF_FFFF);
        model(2, -16'sd32768, 10'd50, pr, ps); chk("pin_ovf_neg", longint'(pr), 64'h8000_0000);
`else
        chk("pin_ovf_pos", longint'(pr), 64'h4001_7FFF);
        model(2, -16'sd32768, 10'd50, pr, ps); chk("pin_ovf_neg", longint'(pr), 64'h0000_0000);
`endif

        run("n0",       0, 16'd9,     10'd10,   0, -1);
        run("n3_x2",    3, 16'd2,     10'd20,   0, 4);
        run("n3_xm1",   3, 16'hFFFF,  10'd20,   0, -1);
        run("ovf_pos",  2, 16'h7FFF,  10'd40,   0, -1);
        run("ovf_neg",  2, 16'h8000,  10'd50,   0, -1);
        run("invalid",  11, 16'd1,    10'd0,    0, -1);
        run("inv_stall", 31, 16'd1,   10'd0,    2, -1);
        run("stall4",   3, 16'd2,     10'd20,   4, -1);
        run("wrap",     3, 16'd5,     10'd1022, 0, -1);

        // Reset in the middle of a MAC cycle of an N=5 run.
        @(negedge clk);
        start = 1'b1; N = 5'd5; x = 16'd3; coef_base = 10'd100;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_rd_en",  longint'(coef_rd_en), 64'd0);
        chk("abort_addr",   longint'(coef_addr), 64'd0);
        chk("abort_wr_out", longint'(wr_out), 64'd0);
        chk("abort_result", longint'(result), 64'd0);
        chk("abort_status", longint'(status), 64'd0);
        chk("abort_busy",   longint'(busy), 64'd0);
        chk("abort_fc",     longint'(FC), 64'd0);
        @(negedge clk); rst = 1'b1;
        begin
            int stray;
            stray = 0;
            repeat (12) begin
                @(posedge clk); #1;
                if (wr_out || FC || busy) stray++;
            end
            chk("abort_no_partial", longint'(stray), 64'd0);
        end
        run("n5_after_rst", 5, 16'd3, 10'd100, 0, 6);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
